apb2iob: RTL

APB3 completer (slave) bridge that turns each APB transfer into one internal IOB request and returns the IOB response as the APB completion. It sits at the APB end of a peripheral segment and lets IOB-native peripherals, such as register files and local RAMs, sit behind the APB bus. It is the responder counterpart of the IOB-to-APB requester bridge. The block has one outstanding transaction at most, and it covers hung IOB targets with a cycle timeout.

---
 rtl/apb2iob.sv | 111 +++++++++++
 1 files changed

// File: rtl/apb2iob.sv
// ============================================================================
// apb2iob : APB3 completer that forwards each transfer as one IOB request
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module apb2iob #(
  parameter logic [19:0] BASE_HI = 20'h00000,
  parameter int          TO_W    = 8,
  parameter int          TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic        pready,
  output logic [31:0] prdata,
  output logic        pslverr,
  output logic        ibval,
  input  logic        ibrdy,
  output logic [31:0] ibadr,
  output logic [3:0]  ibwen,
  output logic [31:0] ibwdat,
  input  logic [31:0] ibrdat
);

  localparam bit            c_TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] c_TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [TO_W-1:0] c_CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  logic [11:0]     r_paddr;
  logic            r_pwrite;
  logic [31:0]     r_pwdata;
  logic [TO_W-1:0] r_cnt;
  logic [31:0]     r_prdata;
  logic            r_pslverr;

  logic w_setup;
  logic w_expired;

  assign w_setup   = psel & ~penable;
  assign w_expired = c_TO_EN && (r_cnt == c_TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_paddr   <= '0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
      r_cnt     <= '0;
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // An access phase without a preceding setup never starts a request.
          if (w_setup) begin
            r_paddr  <= paddr;
            r_pwrite <= pwrite;
            r_pwdata <= pwdata;
            r_cnt    <= '0;
            r_state  <= S_REQ;
          end
        end
        S_REQ: begin
          // ibrdy takes priority over a timeout expiring in the same cycle.
          if (ibrdy) begin
            if (!r_pwrite) begin
              r_prdata <= ibrdat;
            end
            r_pslverr <= 1'b0;
            r_state   <= S_RESP;
          end else if (w_expired) begin
            r_pslverr <= 1'b1;
            r_prdata  <= '0;
            r_state   <= S_RESP;
          end else if (r_cnt != c_CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ibval   = (r_state == S_REQ);
  assign pready  = (r_state == S_RESP);
  assign pslverr = (r_state == S_RESP) & r_pslverr;
  assign prdata  = r_prdata;
  assign ibadr   = {BASE_HI, r_paddr};
  assign ibwen   = {4{r_pwrite}};
  assign ibwdat  = r_pwdata;

endmodule

`default_nettype wire
